// File: rtl/mul_div_unit_pkg.sv
// Shared CPU encodings: multiply/divide ops, mul/div FSM states and ALU controls.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_NOR  = 4'h5,
    ALU_SLT  = 4'h6,
    ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_SRA  = 4'hA,
    ALU_LUI  = 4'hB
  } alu_ctrl_e;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return op inside {OP_MULT, OP_DIV};
  endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One iteration of the shared datapath: LSB-first shift-add for multiply,
// restoring shift-subtract for divide, both through a single adder.
module mdu_step
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_ctrl_e          ctrl,
  input  logic [WIDTH-1:0]   hi,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   operand,
  output logic [WIDTH-1:0]   hi_next,
  output logic [WIDTH-1:0]   lo_next
);

  logic             is_sub;
  logic [WIDTH:0]   addend_a;
  logic [WIDTH:0]   addend_b;
  logic [WIDTH+1:0] result;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    is_sub   = (ctrl == ALU_SUB);
    addend_a = is_sub ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    addend_b = {1'b0, operand};
    if (!is_sub && !lo[0]) addend_b = '0;

    // Subtract is add of the inverted operand plus one; bit WIDTH+1 is the borrow.
    result = {1'b0, addend_a} + ({1'b0, addend_b} ^ {(WIDTH+2){is_sub}})
           + (WIDTH+2)'(is_sub);

    hi_next = result[WIDTH:1];
    lo_next = {result[0], lo[WIDTH-1:1]};
    if (is_sub) begin
      if (result[WIDTH+1]) begin
        hi_next = addend_a[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_next = result[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit: sign-magnitude operands, WIDTH steps in RUN,
// sign correction and result write in FIX. Latency is fixed at WIDTH+1 edges.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  md_op_e             op_q;
  logic [WIDTH-1:0]   acc_q, shreg_q, operand_q;
  logic               neg_lo_q, neg_hi_q, div_zero_q;

  md_op_e             op_in;
  logic               in_signed, in_div, rs_neg, rt_neg, accept;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  alu_ctrl_e          step_ctrl;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] product, product_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  always_comb begin
    op_in     = md_op_e'(op_i);
    in_signed = op_is_signed(op_in);
    in_div    = op_is_div(op_in);
    rs_neg    = in_signed & rs_i[WIDTH-1];
    rt_neg    = in_signed & rt_i[WIDTH-1];
    rs_mag    = rs_neg ? -rs_i : rs_i;
    rt_mag    = rt_neg ? -rt_i : rt_i;
    accept    = (state_q == IDLE) && start_i && !flush_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (flush_i) state_d = IDLE;
               else if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    step_ctrl = op_is_div(op_q) ? ALU_SUB : ALU_ADD;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .ctrl    (step_ctrl),
    .hi      (acc_q),
    .lo      (shreg_q),
    .operand (operand_q),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Magnitude results are re-signed here; modulo wrap makes MIN / -1 fall out naturally.
  always_comb begin
    product     = {acc_q, shreg_q};
    product_fix = neg_lo_q ? -product : product;
    fix_hi      = product_fix[2*WIDTH-1:WIDTH];
    fix_lo      = product_fix[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      fix_hi = neg_hi_q ? -acc_q : acc_q;
      fix_lo = div_zero_q ? {WIDTH{1'b1}} : (neg_lo_q ? -shreg_q : shreg_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      acc_q      <= '0;
      shreg_q    <= '0;
      operand_q  <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_o <= 1'b0;
      busy_o <= (state_d != IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q       <= op_in;
            cnt_q      <= '0;
            acc_q      <= '0;
            neg_lo_q   <= rs_neg ^ rt_neg;
            neg_hi_q   <= in_div & rs_neg;
            div_zero_q <= in_div && (rt_i == '0);
            // Divide shifts the dividend out of the low register; multiply shifts the multiplier.
            shreg_q    <= in_div ? rs_mag : rt_mag;
            operand_q  <= in_div ? rt_mag : rs_mag;
          end
        end
        RUN: begin
          if (!flush_i) begin
            acc_q   <= step_hi;
            shreg_q <= step_lo;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush_i) begin
            hi_o   <= fix_hi;
            lo_o   <= fix_lo;
            done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: transaction-level reference model with a
// per-cycle compare, plus directed vectors carrying hand-computed results.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start, flush;
  logic [1:0]   op;
  logic [W-1:0] rs, rt;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .rs_i    (rs),
    .rt_i    (rt),
    .flush_i (flush),
    .busy_o  (busy),
    .done_o  (done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers; returns {hi, lo}.
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Transaction model: a result becomes visible W+1 edges after acceptance.
  logic [63:0] m_pend = '0;
  logic [63:0] m_hilo = '0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_hilo = '0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start && !flush) begin
          m_pend = model_result(op, rs, rt);
          m_left = W + 1;
          m_busy = 1'b1;
        end
      end else if (flush) begin
        m_left = 0;
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_hilo = m_pend;
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", 64'(busy), 64'(m_busy));
    check("cyc_done", 64'(done), 64'(m_done));
    check("cyc_hi_lo", {hi, lo}, m_hilo);
  end

  // Starts an op, optionally pokes start_i once while busy, and waits for done_o.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name, input int poke_at);
    int n;
    #1;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #2;
    start = 1'b0; op = 2'($urandom); rs = $urandom; rt = $urandom;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      #1;
      start = (n == poke_at);
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'(33));
    check({name, "_hi"}, 64'(hi), 64'(exp_hi));
    check({name, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  // Starts an op and flushes it so the flush is sampled at edge k+flush_at.
  task automatic flush_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input logic [63:0] prev, input string name);
    int n;
    bit seen;
    #1;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk);
    #2;
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    repeat (40) begin
      flush = (n == flush_at - 1);
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
      #1;
    end
    flush = 1'b0;
    check({name, "_no_done"}, 64'(seen), 64'(0));
    check({name, "_hi_lo"}, {hi, lo}, prev);
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    start = 1'b0; flush = 1'b0; op = 2'b00; rs = '0; rt = '0;
    @(posedge clk);
    #2;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi_lo", {hi, lo}, 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 0);
    @(posedge clk);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 0);
    @(posedge clk);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 0);
    run_op(2'b11, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, "divu_zero_b2b", 0);
    @(posedge clk);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf", 0);
    @(posedge clk);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_neg", 0);
    @(posedge clk);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_neg_divisor", 0);
    @(posedge clk);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_minmin", 0);
    @(posedge clk);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_poke_run", 5);
    run_op(2'b01, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, "multu_poke_fix", 32);
    @(posedge clk);

    flush_op(2'b01, 32'd5, 32'd6, 10, {32'h1, 32'h2345_6780}, "flush_step10");
    flush_op(2'b10, 32'd9, 32'd3, 33, {32'h1, 32'h2345_6780}, "flush_fix");

    #1;
    start = 1'b1; flush = 1'b1; op = 2'b01; rs = 32'd3; rt = 32'd3;
    @(posedge clk);
    #1;
    check("idle_flush_busy", 64'(busy), 64'(0));
    start = 1'b0; flush = 1'b0;

    @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; rs = 32'hDEAD_BEEF; rt = 32'h1234;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrun_reset_busy", 64'(busy), 64'(0));
    check("midrun_reset_done", 64'(done), 64'(0));
    check("midrun_reset_hi_lo", {hi, lo}, 64'(0));
    @(posedge clk);
    #2 rst = 1'b0;

    run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, "after_reset", 0);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
